hex_disp_arbiter: RTL and testbench

Shares the 8-digit seven-segment display between up to N_REQ independent requesters, e.g. a counter, a received UART byte and an alarm code. Round-robin arbitration with a guaranteed minimum dwell time per owner and a blank gap between owners. Drives the 32-bit display word and the display enable of the hex8 scan block, which feeds hc595_driver. Sits between the application sources and hex8 inside the display top level.

---
 rtl/hex_disp_arbiter_pkg.sv | 25 ++
 rtl/hex_disp_arbiter_rr_pick.sv | 48 ++++
 rtl/hex_disp_arbiter.sv | 170 +++++++++++++++++
 tb/tb_hex_disp_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_arbiter_pkg.sv
// Shared definitions for the seven-segment display arbiter.
// Holds the display word width, the FSM state encodings, the word shown
// while the display is blanked, and a small sizing helper.
package hex_disp_arbiter_pkg;

  localparam int DISP_W = 32;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHOW  = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

  // Word driven to the scan block whenever nobody owns the display
  localparam logic [DISP_W-1:0] DISP_BLANK = 32'h0;

  // Largest of three values; used to size the shared dwell/blank counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/hex_disp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first asserted request found scanning from ptr upward with
// wrap-around modulo N_REQ.
// Ports:
//   req    in  N_REQ  request vector
//   ptr    in  3      index where the scan starts (must be < N_REQ)
//   valid  out 1      at least one request is asserted
//   idx    out 3      index of the selected request
//   onehot out N_REQ  one-hot form of idx, all zero when valid is low
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       ptr,
  output logic             valid,
  output logic [2:0]       idx,
  output logic [N_REQ-1:0] onehot
);

  // Zero-padded copy so a 3-bit index is always in range
  logic [7:0] req_pad;
  logic [3:0] pos;

  assign req_pad = 8'(req);

  // Scan from the far end back toward ptr so the candidate closest to ptr
  // is written last and wins, without needing an early loop exit.
  always_comb begin
    valid = 1'b0;
    idx   = 3'd0;
    pos   = 4'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + 4'(k);
      if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
      if (req_pad[pos[2:0]]) begin
        valid = 1'b1;
        idx   = pos[2:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign onehot[gi] = valid && (idx == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/hex_disp_arbiter.sv
// hex_disp_arbiter: shares the 8-digit seven-segment display between
// N_REQ requesters. Round-robin selection, a minimum dwell per owner while
// others wait, and an optional blank gap between owners.
// Ports:
//   clk        in  1           system clock
//   reset      in  1           synchronous, active-high reset
//   req        in  N_REQ       level requests; hold high to keep the display
//   req_data   in  N_REQ*32    requester i word at [32*i+31:32*i]
//   grant      out N_REQ       one-hot current owner, zero outside SHOW
//   owner      out 3           index of current or last owner
//   disp_data  out 32          word to the scan block
//   disp_en    out 1           display enable to the scan block
module hex_disp_arbiter
  import hex_disp_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DWELL_CYC = 50_000_000,
  parameter int BLANK_CYC = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DISP_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [2:0]              owner,
  output logic [DISP_W-1:0]       disp_data,
  output logic                    disp_en
);

  // One counter serves both dwell and blank timing
  localparam int CNT_W = $clog2(max3(DWELL_CYC, BLANK_CYC, 2));
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam int BLANK_LAST_I = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_LAST_I);

  logic [1:0]        state_reg, state_next;
  logic [N_REQ-1:0]  grant_reg, grant_next;
  logic [2:0]        owner_reg, owner_next;
  logic [DISP_W-1:0] data_reg, data_next;
  logic              en_reg, en_next;
  logic [2:0]        ptr_reg, ptr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic              pick_valid;
  logic [2:0]        pick_idx;
  logic [N_REQ-1:0]  pick_onehot;

  logic [DISP_W-1:0] word [N_REQ];
  logic [DISP_W-1:0] owner_word;
  logic [DISP_W-1:0] pick_word;
  logic              owner_drop;
  logic              others_waiting;
  logic              dwell_done;
  logic [2:0]        owner_inc;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
      assign word[gi] = req_data[gi*DISP_W +: DISP_W];
    end
  endgenerate

  // grant_reg is the one-hot owner while in SHOW, so it doubles as the
  // owner's select mask; the arbitration result selects the new word.
  always_comb begin
    owner_word = DISP_BLANK;
    pick_word  = DISP_BLANK;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_reg[i])   owner_word = word[i];
      if (pick_onehot[i]) pick_word  = word[i];
    end
  end

  assign owner_drop     = ~|(req & grant_reg);
  assign others_waiting = |(req & ~grant_reg);
  assign dwell_done     = (cnt_reg == DWELL_LAST);
  assign owner_inc      = (owner_reg == 3'(N_REQ - 1)) ? 3'd0 : owner_reg + 3'd1;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    owner_next = owner_reg;
    data_next  = data_reg;
    en_next    = en_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        grant_next = '0;
        data_next  = DISP_BLANK;
        en_next    = 1'b0;
        if (pick_valid) begin
          grant_next = pick_onehot;
          owner_next = pick_idx;
          data_next  = pick_word;
          en_next    = 1'b1;
          cnt_next   = '0;
          state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        // An owner drop takes priority; a coincident expiry ends the same way
        if (owner_drop || (dwell_done && others_waiting)) begin
          grant_next = '0;
          data_next  = DISP_BLANK;
          en_next    = 1'b0;
          ptr_next   = owner_inc;
          cnt_next   = '0;
          state_next = (BLANK_CYC > 0) ? ST_BLANK : ST_IDLE;
        end else begin
          data_next = owner_word;
          en_next   = 1'b1;
          // Saturate: an unchallenged owner keeps the display indefinitely
          if (!dwell_done) cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_BLANK: begin
        grant_next = '0;
        data_next  = DISP_BLANK;
        en_next    = 1'b0;
        if (cnt_reg == BLANK_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        grant_next = '0;
        data_next  = DISP_BLANK;
        en_next    = 1'b0;
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      owner_reg <= 3'd0;
      data_reg  <= DISP_BLANK;
      en_reg    <= 1'b0;
      ptr_reg   <= 3'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      data_reg  <= data_next;
      en_reg    <= en_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign grant     = grant_reg;
  assign owner     = owner_reg;
  assign disp_data = data_reg;
  assign disp_en   = en_reg;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// Testbench for hex_disp_arbiter. Two instances share stimulus: dut_a with
// a 2-cycle blank gap and dut_z with no gap, both with an 8-cycle dwell.
module tb_hex_disp_arbiter;

  localparam int DWELL = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   req = 4'b0;
  logic [127:0] req_data = '0;

  logic [3:0]  grant_a, grant_z;
  logic [2:0]  owner_a, owner_z;
  logic [31:0] disp_data_a, disp_data_z;
  logic        disp_en_a, disp_en_z;
  logic [39:0] obs_a, obs_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hex_disp_arbiter #(.N_REQ(4), .DWELL_CYC(DWELL), .BLANK_CYC(2)) dut_a (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant_a), .owner(owner_a), .disp_data(disp_data_a), .disp_en(disp_en_a)
  );

  hex_disp_arbiter #(.N_REQ(4), .DWELL_CYC(DWELL), .BLANK_CYC(0)) dut_z (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .grant(grant_z), .owner(owner_z), .disp_data(disp_data_z), .disp_en(disp_en_z)
  );

  assign obs_a = {grant_a, owner_a, disp_data_a, disp_en_a};
  assign obs_z = {grant_z, owner_z, disp_data_z, disp_en_z};

  // Reference model, one slot per instance (0: gap 2, 1: no gap).
  // cur  : index of the requester on screen, -1 when nobody is shown
  // shown: cycles the current owner has been on screen
  // gap  : blank cycles still to elapse before arbitration resumes
  // rr   : where the next search for a requester starts
  int          cur[2], shown[2], gap[2], rr[2], last[2];
  logic [31:0] dval[2];

  task automatic model_step(input int b, input int blank);
    bit found;
    int i;
    if (reset) begin
      cur[b] = -1; shown[b] = 0; gap[b] = 0; rr[b] = 0; last[b] = 0; dval[b] = 32'h0;
    end else if (cur[b] >= 0) begin
      if (!req[cur[b]] || (shown[b] >= DWELL && (req & ~(4'b1 << cur[b])) != 4'b0)) begin
        rr[b]  = (cur[b] + 1) % 4;
        cur[b] = -1;
        gap[b] = blank;
      end else begin
        shown[b]++;
        dval[b] = req_data[32*cur[b] +: 32];
      end
    end else if (gap[b] > 0) begin
      gap[b]--;
    end else begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        i = (rr[b] + k) % 4;
        if (!found && req[i]) begin
          found    = 1'b1;
          cur[b]   = i;
          last[b]  = i;
          shown[b] = 1;
          dval[b]  = req_data[32*i +: 32];
        end
      end
    end
  endtask

  function automatic logic [39:0] expv(input int b);
    logic [3:0] g;
    g = (cur[b] >= 0) ? (4'b1 << cur[b]) : 4'b0;
    return {g, 3'(last[b]), (cur[b] >= 0) ? dval[b] : 32'h0, cur[b] >= 0};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, 2);
    model_step(1, 0);
    #1;
  endtask

  task automatic apply_reset(input logic [3:0] r);
    reset = 1'b1;
    req = r;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req_data = {$urandom, $urandom, $urandom, $urandom};
    reset = 1'b1;
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      if ({grant_a, disp_en_a, disp_data_a} !== 37'h0) begin
        errors++; $display("FAIL reset_hold_a cyc=%0d got=%h want=0", c, {grant_a, disp_en_a, disp_data_a});
      end
      checks++;
      if ({grant_z, disp_en_z, disp_data_z} !== 37'h0) begin
        errors++; $display("FAIL reset_hold_z cyc=%0d got=%h want=0", c, {grant_z, disp_en_z, disp_data_z});
      end
      checks++;
    end
    reset = 1'b0;
    tick();
    if (grant_a !== 4'b0001 || disp_data_a !== req_data[31:0]) begin
      errors++; $display("FAIL reset_release_a got grant=%b data=%h want grant=0001 data=%h", grant_a, disp_data_a, req_data[31:0]);
    end
    checks++;
    if (obs_z !== expv(1)) begin
      errors++; $display("FAIL reset_release_z got=%h want=%h", obs_z, expv(1));
    end
    checks++;
  endtask

  task automatic test_single();
    req_data[95:64] = 32'h1234_5678;
    apply_reset(4'b0100);
    tick();
    if (grant_a !== 4'b0100 || disp_data_a !== 32'h1234_5678 || disp_en_a !== 1'b1) begin
      errors++; $display("FAIL single_grant got grant=%b data=%h en=%b want 0100/12345678/1", grant_a, disp_data_a, disp_en_a);
    end
    checks++;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (grant_a !== 4'b0100 || grant_z !== 4'b0100) begin
        errors++; $display("FAIL single_hold cyc=%0d got a=%b z=%b want 0100", c, grant_a, grant_z);
      end
      checks++;
    end
    req_data[95:64] = 32'hABCD_0000;
    tick();
    if (disp_data_a !== 32'hABCD_0000 || disp_data_z !== 32'hABCD_0000) begin
      errors++; $display("FAIL single_live_update got a=%h z=%h want abcd0000", disp_data_a, disp_data_z);
    end
    checks++;
    if (owner_a !== 3'd2) begin
      errors++; $display("FAIL single_owner got=%0d want=2", owner_a);
    end
    checks++;
  endtask

  task automatic test_contention();
    logic [3:0] want_a, want_z;
    apply_reset(4'b0011);
    for (int c = 0; c < 23; c++) begin
      tick();
      want_a = (c < 8) ? 4'b0001 : (c < 11) ? 4'b0000 : (c < 19) ? 4'b0010 : (c < 22) ? 4'b0000 : 4'b0001;
      want_z = (c < 8) ? 4'b0001 : (c < 9) ? 4'b0000 : (c < 17) ? 4'b0010 : (c < 18) ? 4'b0000 : 4'b0001;
      if (grant_a !== want_a || disp_en_a !== (want_a != 4'b0)) begin
        errors++; $display("FAIL contention_a cyc=%0d got grant=%b en=%b want grant=%b", c, grant_a, disp_en_a, want_a);
      end
      checks++;
      if (c < 19 && grant_z !== want_z) begin
        errors++; $display("FAIL contention_z cyc=%0d got grant=%b want grant=%b", c, grant_z, want_z);
      end
      checks++;
    end
  endtask

  task automatic test_early_release();
    apply_reset(4'b1010);
    tick();
    if (grant_a !== 4'b0010) begin
      errors++; $display("FAIL early_first_owner got=%b want=0010", grant_a);
    end
    checks++;
    for (int c = 0; c < 3; c++) tick();
    req = 4'b1000;
    tick();
    if (grant_a !== 4'b0000 || grant_z !== 4'b0000) begin
      errors++; $display("FAIL early_drop got a=%b z=%b want 0000", grant_a, grant_z);
    end
    checks++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL early_model_a cyc=%0d got=%h want=%h", c, obs_a, expv(0));
      end
      checks++;
      if (obs_z !== expv(1)) begin
        errors++; $display("FAIL early_model_z cyc=%0d got=%h want=%h", c, obs_z, expv(1));
      end
      checks++;
    end
    if (grant_a !== 4'b1000 || owner_a !== 3'd3) begin
      errors++; $display("FAIL early_skip got grant=%b owner=%0d want 1000/3", grant_a, owner_a);
    end
    checks++;
  endtask

  task automatic test_wrap_no_blank();
    apply_reset(4'b1000);
    tick();
    req = 4'b1001;
    for (int c = 0; c < 7; c++) begin
      tick();
      if (grant_z !== 4'b1000) begin
        errors++; $display("FAIL wrap_hold cyc=%0d got=%b want=1000", c, grant_z);
      end
      checks++;
    end
    tick();
    if (grant_z !== 4'b0000 || disp_en_z !== 1'b0) begin
      errors++; $display("FAIL wrap_idle got grant=%b en=%b want 0000/0", grant_z, disp_en_z);
    end
    checks++;
    tick();
    if (grant_z !== 4'b0001 || owner_z !== 3'd0 || disp_en_z !== 1'b1) begin
      errors++; $display("FAIL wrap_regrant got grant=%b owner=%0d en=%b want 0001/0/1", grant_z, owner_z, disp_en_z);
    end
    checks++;
    if (obs_a !== expv(0)) begin
      errors++; $display("FAIL wrap_model_a got=%h want=%h", obs_a, expv(0));
    end
    checks++;
  endtask

  task automatic test_reset_mid_show();
    apply_reset(4'b0001);
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    for (int c = 0; c < 3; c++) tick();
    if (grant_a !== 4'b0100) begin
      errors++; $display("FAIL midreset_setup got=%b want=0100", grant_a);
    end
    checks++;
    for (int c = 0; c < 5; c++) tick();
    reset = 1'b1;
    req = 4'b0101;
    tick();
    if (obs_a !== 40'h0 || obs_z !== 40'h0) begin
      errors++; $display("FAIL midreset_clear got a=%h z=%h want 0", obs_a, obs_z);
    end
    checks++;
    reset = 1'b0;
    tick();
    if (grant_a !== 4'b0001 || grant_z !== 4'b0001) begin
      errors++; $display("FAIL midreset_ptr got a=%b z=%b want 0001", grant_a, grant_z);
    end
    checks++;
  endtask

  task automatic test_random();
    apply_reset(4'b0000);
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 9) == 0) req = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) req_data[32*i +: 32] = $urandom;
      tick();
      if (obs_a !== expv(0)) begin
        errors++; $display("FAIL random_a cyc=%0d got=%h want=%h", c, obs_a, expv(0));
      end
      checks++;
      if (obs_z !== expv(1)) begin
        errors++; $display("FAIL random_z cyc=%0d got=%h want=%h", c, obs_z, expv(1));
      end
      checks++;
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_wrap_no_blank();
    test_reset_mid_show();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
